// File: rtl/gray_ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_ptr_sync: destination-domain Gray pointer synchronizer with binary  |
// | conversion, change/delta reporting, valid qualifier and integrity check. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gray_ptr_sync #(
  parameter int ADDR_WIDTH = 4,
  parameter int STAGES     = 2,
  parameter int CHECK_EN   = 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [ADDR_WIDTH:0]   ptr_gray_in,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH:0]   sync_gray,
  output logic [ADDR_WIDTH:0]   sync_bin,
  output logic                  ptr_changed,
  output logic [ADDR_WIDTH:0]   ptr_delta,
  output logic                  sync_valid,
  output logic                  gray_err,
  output logic [7:0]            err_cnt
);

  localparam int          PW          = ADDR_WIDTH + 1;
  localparam logic [2:0]  c_VALID_CNT = 3'(STAGES + 1);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be in 2..4");
  end

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] r_sync [STAGES];
  logic [PW-1:0] r_prev;
  logic [PW-1:0] r_bin;
  logic          r_changed;
  logic [PW-1:0] r_delta;
  logic [2:0]    r_vcnt;

  logic [PW-1:0] w_sync;
  logic [PW-1:0] w_bin_new;
  logic          w_valid;
  logic          w_diff;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= ptr_gray_in;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_vcnt <= '0;
    end else if (r_vcnt != c_VALID_CNT) begin
      r_vcnt <= r_vcnt + 3'd1;
    end
  end

  assign w_sync    = r_sync[STAGES-1];
  assign w_bin_new = gray2bin(w_sync);
  assign w_valid   = (r_vcnt == c_VALID_CNT);
  assign w_diff    = (w_sync != r_prev);

  // r_bin always equals gray2bin(r_prev), so it serves as the old binary value.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_prev    <= '0;
      r_bin     <= '0;
      r_changed <= 1'b0;
      r_delta   <= '0;
    end else begin
      r_prev    <= w_sync;
      r_bin     <= w_bin_new;
      r_changed <= w_valid && w_diff;
      if (w_valid && w_diff) begin
        r_delta <= w_bin_new - r_bin;
      end
    end
  end

  if (CHECK_EN != 0) begin : g_chk
    logic [PW-1:0] w_xor;
    logic          w_viol;
    logic          r_gray_err;
    logic [7:0]    r_err_cnt;

    assign w_xor  = w_sync ^ r_prev;
    assign w_viol = w_valid && ((w_xor & (w_xor - PW'(1))) != '0);

    // A violation on the same edge as a clear wins and restarts the count at 1.
    always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
        r_gray_err <= 1'b0;
        r_err_cnt  <= '0;
      end else if (w_viol) begin
        r_gray_err <= 1'b1;
        if (err_clr)                  r_err_cnt <= 8'd1;
        else if (r_err_cnt != 8'hFF)  r_err_cnt <= r_err_cnt + 8'd1;
      end else if (err_clr) begin
        r_gray_err <= 1'b0;
        r_err_cnt  <= '0;
      end
    end

    assign gray_err = r_gray_err;
    assign err_cnt  = r_err_cnt;
  end else begin : g_nochk
    logic w_unused_clr;
    assign w_unused_clr = err_clr;
    assign gray_err     = 1'b0;
    assign err_cnt      = '0;
  end

  assign sync_gray   = w_sync;
  assign sync_bin    = r_bin;
  assign ptr_changed = r_changed;
  assign ptr_delta   = r_delta;
  assign sync_valid  = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gray_ptr_sync: three instances (2-stage checked, 4-stage checked,     |
// | 4-stage unchecked) against an input-history reference model.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] pin = '0;
  logic       clr = 1'b0;

  logic [4:0] o_sg    [3];
  logic [4:0] o_bin   [3];
  logic       o_chg   [3];
  logic [4:0] o_delta [3];
  logic       o_valid [3];
  logic       o_err   [3];
  logic [7:0] o_cnt   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_ptr_sync #(.ADDR_WIDTH(4), .STAGES(2), .CHECK_EN(1)) dut0 (
    .wclk(clk), .wrst(rst), .ptr_gray_in(pin), .err_clr(clr),
    .sync_gray(o_sg[0]), .sync_bin(o_bin[0]), .ptr_changed(o_chg[0]),
    .ptr_delta(o_delta[0]), .sync_valid(o_valid[0]), .gray_err(o_err[0]),
    .err_cnt(o_cnt[0]));

  gray_ptr_sync #(.ADDR_WIDTH(4), .STAGES(4), .CHECK_EN(1)) dut1 (
    .wclk(clk), .wrst(rst), .ptr_gray_in(pin), .err_clr(clr),
    .sync_gray(o_sg[1]), .sync_bin(o_bin[1]), .ptr_changed(o_chg[1]),
    .ptr_delta(o_delta[1]), .sync_valid(o_valid[1]), .gray_err(o_err[1]),
    .err_cnt(o_cnt[1]));

  gray_ptr_sync #(.ADDR_WIDTH(4), .STAGES(4), .CHECK_EN(0)) dut2 (
    .wclk(clk), .wrst(rst), .ptr_gray_in(pin), .err_clr(clr),
    .sync_gray(o_sg[2]), .sync_bin(o_bin[2]), .ptr_changed(o_chg[2]),
    .ptr_delta(o_delta[2]), .sync_valid(o_valid[2]), .gray_err(o_err[2]),
    .err_cnt(o_cnt[2]));

  // Reference model: the synchronized value is simply the input seen S edges
  // ago; everything else follows from comparing successive synchronized values.
  int         m_n     [3];
  logic [4:0] m_sg    [3];
  logic [4:0] m_sgo   [3];
  logic [4:0] m_bin   [3];
  logic       m_chg   [3];
  logic [4:0] m_delta [3];
  logic       m_err   [3];
  int         m_cnt   [3];
  logic [4:0] hist    [3][8];

  function automatic int st(input int m);
    return (m == 0) ? 2 : 4;
  endfunction

  function automatic bit chk_en(input int m);
    return m != 2;
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b = g;
    for (int s = 1; s < 5; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [4:0] b2g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_n[m] = 0; m_sg[m] = '0; m_sgo[m] = '0; m_bin[m] = '0;
      m_chg[m] = 1'b0; m_delta[m] = '0; m_err[m] = 1'b0; m_cnt[m] = 0;
      for (int k = 0; k < 8; k++) hist[m][k] = '0;
    end
  endtask

  task automatic model_update();
    logic [4:0] a;
    logic [4:0] b;
    bit         pv;
    for (int m = 0; m < 3; m++) begin
      a  = m_sg[m];
      b  = m_sgo[m];
      pv = (m_n[m] >= st(m) + 1);
      for (int k = 7; k > 0; k--) hist[m][k] = hist[m][k-1];
      hist[m][0] = pin;
      m_bin[m] = g2b(a);
      m_chg[m] = pv && (a != b);
      if (m_chg[m]) m_delta[m] = g2b(a) - g2b(b);
      if (chk_en(m) && pv && $countones(a ^ b) > 1) begin
        m_err[m] = 1'b1;
        m_cnt[m] = clr ? 1 : ((m_cnt[m] < 255) ? m_cnt[m] + 1 : 255);
      end else if (clr) begin
        m_err[m] = 1'b0;
        m_cnt[m] = 0;
      end
      if (m_n[m] < 1000) m_n[m]++;
      m_sgo[m] = a;
      m_sg[m]  = (m_n[m] >= st(m)) ? hist[m][st(m)-1] : 5'd0;
    end
  endtask

  task automatic cmp(input string name, input int m, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[dut%0d] at %0t: got=%0d expected=%0d", name, m, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      cmp("sync_gray",   m, 32'(o_sg[m]),    32'(m_sg[m]));
      cmp("sync_bin",    m, 32'(o_bin[m]),   32'(m_bin[m]));
      cmp("ptr_changed", m, 32'(o_chg[m]),   32'(m_chg[m]));
      cmp("ptr_delta",   m, 32'(o_delta[m]), 32'(m_delta[m]));
      cmp("sync_valid",  m, 32'(o_valid[m]), 32'(m_n[m] >= st(m) + 1));
      cmp("gray_err",    m, 32'(o_err[m]),   32'(m_err[m]));
      cmp("err_cnt",     m, 32'(o_cnt[m]),   32'(m_cnt[m]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_update();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic [4:0] in;
    logic       clr;
    logic [4:0] sg;
    logic [4:0] bin;
    logic       chg;
    logic [4:0] d;
    logic       v;
    logic       e;
    logic [7:0] n;
  } vec_t;

  vec_t tbl [16];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cur_bin;
    int pulses;
    int lat;
    bit found;
    model_reset();

    // Expected responses of the 2-stage checked instance, one row per edge.
    tbl[0]  = '{5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 8'd0};
    tbl[1]  = '{5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 8'd0};
    tbl[2]  = '{5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 8'd0};
    tbl[3]  = '{5'd1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 8'd0};
    tbl[4]  = '{5'd1, 1'b0, 5'd1, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 8'd0};
    tbl[5]  = '{5'd1, 1'b0, 5'd1, 5'd1, 1'b1, 5'd1,  1'b1, 1'b0, 8'd0};
    tbl[6]  = '{5'd0, 1'b0, 5'd1, 5'd1, 1'b0, 5'd1,  1'b1, 1'b0, 8'd0};
    tbl[7]  = '{5'd0, 1'b0, 5'd0, 5'd1, 1'b0, 5'd1,  1'b1, 1'b0, 8'd0};
    tbl[8]  = '{5'd7, 1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{5'd7, 1'b0, 5'd7, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{5'd7, 1'b0, 5'd7, 5'd5, 1'b1, 5'd5,  1'b1, 1'b1, 8'd1};
    tbl[11] = '{5'd7, 1'b1, 5'd7, 5'd5, 1'b0, 5'd5,  1'b1, 1'b0, 8'd0};
    tbl[12] = '{5'd0, 1'b0, 5'd7, 5'd5, 1'b0, 5'd5,  1'b1, 1'b0, 8'd0};
    tbl[13] = '{5'd0, 1'b0, 5'd0, 5'd5, 1'b0, 5'd5,  1'b1, 1'b0, 8'd0};
    tbl[14] = '{5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd27, 1'b1, 1'b1, 8'd1};
    tbl[15] = '{5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd27, 1'b1, 1'b1, 8'd1};

    // Reset held for three cycles: everything reads zero.
    for (int k = 0; k < 3; k++) begin
      step();
      cmp("rst_sync_gray", 0, 32'(o_sg[0]), 0);
      cmp("rst_valid",     0, 32'(o_valid[0]), 0);
      cmp("rst_err_cnt",   0, 32'(o_cnt[0]), 0);
    end
    rst = 1'b0;

    for (int r = 0; r < 16; r++) begin
      pin = tbl[r].in;
      clr = tbl[r].clr;
      step();
      cmp("tbl_sync_gray", 0, 32'(o_sg[0]),    32'(tbl[r].sg));
      cmp("tbl_sync_bin",  0, 32'(o_bin[0]),   32'(tbl[r].bin));
      cmp("tbl_changed",   0, 32'(o_chg[0]),   32'(tbl[r].chg));
      cmp("tbl_delta",     0, 32'(o_delta[0]), 32'(tbl[r].d));
      cmp("tbl_valid",     0, 32'(o_valid[0]), 32'(tbl[r].v));
      cmp("tbl_gray_err",  0, 32'(o_err[0]),   32'(tbl[r].e));
      cmp("tbl_err_cnt",   0, 32'(o_cnt[0]),   32'(tbl[r].n));
    end
    clr = 1'b0;

    // Let the deeper instances settle, then clear the sticky flags.
    repeat (4) step();
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Full Gray count through the wrap, one step every two cycles.
    pulses = 0;
    for (int i = 1; i <= 32; i++) begin
      pin = b2g(i % 32);
      for (int k = 0; k < 2; k++) begin
        step();
        if (o_chg[0]) begin
          pulses++;
          cmp("wrap_delta", 0, 32'(o_delta[0]), 1);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (o_chg[0]) begin
        pulses++;
        cmp("wrap_delta", 0, 32'(o_delta[0]), 1);
      end
    end
    cmp("wrap_pulses",   0, 32'(pulses), 32);
    cmp("wrap_gray_err", 0, 32'(o_err[0]), 0);

    // Saturation: a 3-bit flip every cycle.
    for (int k = 0; k < 310; k++) begin
      pin = (k % 2 == 0) ? 5'd7 : 5'd0;
      step();
    end
    pin = 5'd0;
    repeat (6) step();
    cmp("sat_err_cnt",    0, 32'(o_cnt[0]), 255);
    cmp("sat_gray_err",   0, 32'(o_err[0]), 1);
    cmp("nochk_err_cnt",  2, 32'(o_cnt[2]), 0);
    cmp("nochk_gray_err", 2, 32'(o_err[2]), 0);

    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    cmp("clr_err_cnt",  0, 32'(o_cnt[0]), 0);
    cmp("clr_gray_err", 0, 32'(o_err[0]), 0);

    // Clear colliding with a violation on the 2-stage instance.
    pin = 5'd7;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    cmp("coll_err_cnt",  0, 32'(o_cnt[0]), 1);
    cmp("coll_gray_err", 0, 32'(o_err[0]), 1);
    repeat (6) step();

    // Random traffic with a mid-run asynchronous reset.
    cur_bin = 5;
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)       cur_bin = (cur_bin + 1) % 32;
      else if (r > 6)  cur_bin = $urandom_range(0, 31);
      pin = b2g(cur_bin);
      clr = ($urandom_range(0, 15) == 0);
      step();

      if (k == 200) begin
        clr = 1'b0;
        @(posedge clk);
        model_update();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        cmp("async_valid4", 1, 32'(o_valid[1]), 0);
        cmp("async_bin4",   1, 32'(o_bin[1]), 0);
        @(negedge clk);
        check_all();
        repeat (2) step();
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
          step();
          cmp("rel_valid2", 0, 32'(o_valid[0]), 32'(e >= 3));
          cmp("rel_valid4", 1, 32'(o_valid[1]), 32'(e >= 5));
        end
        cur_bin = (cur_bin + 1) % 32;
        pin = b2g(cur_bin);
        found = 1'b0;
        lat = 0;
        for (int e = 1; e <= 20 && !found; e++) begin
          step();
          if (o_bin[1] == 5'(cur_bin)) begin
            found = 1'b1;
            lat = e;
          end
        end
        cmp("latency4", 1, 32'(lat), 5);
      end
    end
    clr = 1'b0;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
